req_join_sync: RTL and testbench

- Clocked completion collector for asynchronous request lines.
- Takes REQ_NUM raw req lines from asynchronous flow-control stages and synchronises each into clk.
- Once armed, records which sources have raised req. Emits a single-cycle fin pulse when the join condition is met: all sources, or any source.
- Provides a timeout and a round counter. Bridges the asynchronous req/fin fabric into the clocked control domain, downstream of the async completion-detect stages.

---
 rtl/req_join_sync.sv | 130 +++++++++++++
 tb/tb_req_join_sync.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/req_join_sync.sv
// Synchronises asynchronous req lines into clk and joins them into a fin pulse.
// Supports all-of / any-of joins, a WAIT timeout and a wrapping round counter.
module req_join_sync #(
  parameter int REQ_NUM     = 2,
  parameter int SYNC_STAGES = 2,
  parameter int MODE_ALL    = 1,
  parameter int TIMEOUT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REQ_NUM-1:0]   reqs,
  input  logic                 arm,
  input  logic [TIMEOUT_W-1:0] timeoutLimit,
  output logic                 fin,
  output logic                 timeout,
  output logic [REQ_NUM-1:0]   pending,
  output logic                 busy,
  output logic [7:0]           roundCnt
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FIRE
  } state_e;

  logic [REQ_NUM-1:0]   sync_q [SYNC_STAGES];
  logic [REQ_NUM-1:0]   sync_d [SYNC_STAGES];
  logic [REQ_NUM-1:0]   prev_q, prev_d;
  logic [REQ_NUM-1:0]   pending_q, pending_d;
  logic [TIMEOUT_W-1:0] timer_q, timer_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 fin_q, fin_d;
  logic                 timeout_q, timeout_d;
  logic                 busy_q, busy_d;
  state_e               state_q, state_d;

  logic [REQ_NUM-1:0]   s;
  logic [REQ_NUM-1:0]   rise;
  logic [REQ_NUM-1:0]   pend_nx;
  logic [TIMEOUT_W-1:0] lim_m1;
  logic                 done;
  logic                 expire;

  always_comb begin
    sync_d[0] = reqs;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign s       = sync_q[SYNC_STAGES-1];
  assign prev_d  = s;
  assign rise    = s & ~prev_q;
  assign pend_nx = pending_q & ~rise;
  assign lim_m1  = timeoutLimit - TIMEOUT_W'(1);
  assign expire  = (timeoutLimit != '0) && (timer_q == lim_m1);
  assign done    = (MODE_ALL != 0) ? (pend_nx == '0)
                                   : ((rise & pending_q) != '0);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    timer_d   = timer_q;
    cnt_d     = cnt_q;
    fin_d     = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arm) begin
          state_d   = WAIT;
          pending_d = '1;
          timer_d   = '0;
        end
      end
      WAIT: begin
        pending_d = pend_nx;
        // completion beats a coincident timer expiry
        if (done) begin
          state_d = FIRE;
          fin_d   = 1'b1;
        end else if (expire) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + TIMEOUT_W'(1);
        end
      end
      FIRE: begin
        cnt_d   = cnt_q + 8'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q    <= '0;
      pending_q <= '0;
      timer_q   <= '0;
      cnt_q     <= '0;
      fin_q     <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      state_q   <= IDLE;
    end else begin
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      pending_q <= pending_d;
      timer_q   <= timer_d;
      cnt_q     <= cnt_d;
      fin_q     <= fin_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      state_q   <= state_d;
    end
  end

  assign fin      = fin_q;
  assign timeout  = timeout_q;
  assign pending  = pending_q;
  assign busy     = busy_q;
  assign roundCnt = cnt_q;

endmodule

// File: tb/tb_req_join_sync.sv
// Bench for req_join_sync: an any-join and an all-join instance share stimulus
// and are checked against a cycle model plus a pulse scoreboard.
module tb_req_join_sync;

  localparam int SS = 2;

  typedef struct {
    int       m;
    bit       is_fin;
    int       cyc;
    logic [1:0] pend;
    int       cnt;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  reqs;
  logic        arm;
  logic [15:0] lim;

  logic        fin_w  [2];
  logic        to_w   [2];
  logic [1:0]  pend_w [2];
  logic        busy_w [2];
  logic [7:0]  cnt_w  [2];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // reference model state; index 0 = any-join, 1 = all-join
  logic [1:0] smp [0:SS];
  int         st    [2];
  logic [1:0] pend  [2];
  int         timer [2];
  int         cnt   [2];
  bit         efin  [2];
  bit         eto   [2];
  ev_t        evq [$];

  int fin_seen [2];
  int to_seen  [2];
  int fin_cyc  [2];
  int to_cyc   [2];

  always #5 clk = ~clk;

  req_join_sync #(
    .REQ_NUM(2), .SYNC_STAGES(SS), .MODE_ALL(0), .TIMEOUT_W(16)
  ) u_any (
    .clk(clk), .rst_n(rst_n), .reqs(reqs), .arm(arm),
    .timeoutLimit(lim), .fin(fin_w[0]), .timeout(to_w[0]),
    .pending(pend_w[0]), .busy(busy_w[0]), .roundCnt(cnt_w[0])
  );

  req_join_sync #(
    .REQ_NUM(2), .SYNC_STAGES(SS), .MODE_ALL(1), .TIMEOUT_W(16)
  ) u_all (
    .clk(clk), .rst_n(rst_n), .reqs(reqs), .arm(arm),
    .timeoutLimit(lim), .fin(fin_w[1]), .timeout(to_w[1]),
    .pending(pend_w[1]), .busy(busy_w[1]), .roundCnt(cnt_w[1])
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // model: rise is the synchronised edge seen SS samples late
  always @(posedge clk) begin
    logic [1:0] rise, np;
    bit done;
    cyc++;
    if (!rst_n) begin
      for (int j = 0; j <= SS; j++) smp[j] = '0;
      for (int m = 0; m < 2; m++) begin
        st[m] = 0; pend[m] = '0; timer[m] = 0;
        cnt[m] = 0; efin[m] = 0; eto[m] = 0;
      end
    end else begin
      rise = smp[SS-1] & ~smp[SS];
      for (int m = 0; m < 2; m++) begin
        efin[m] = 0;
        eto[m]  = 0;
        case (st[m])
          0: if (arm) begin
            st[m] = 1; pend[m] = 2'b11; timer[m] = 0;
          end
          1: begin
            np = pend[m] & ~rise;
            done = (m == 1) ? (np == 2'b00) : ((rise & pend[m]) != 2'b00);
            pend[m] = np;
            if (done) begin
              st[m] = 2; efin[m] = 1;
              evq.push_back('{m, 1'b1, cyc, np, cnt[m]});
            end else if (lim != 0 && timer[m] == int'(lim) - 1) begin
              st[m] = 0; eto[m] = 1;
              evq.push_back('{m, 1'b0, cyc, np, cnt[m]});
            end else begin
              timer[m]++;
            end
          end
          default: begin
            cnt[m] = (cnt[m] + 1) % 256;
            st[m] = 0;
          end
        endcase
      end
      for (int j = SS; j > 0; j--) smp[j] = smp[j-1];
      smp[0] = reqs;
    end
  end

  // monitor: per-cycle state plus scoreboard for fin/timeout pulses
  always @(negedge clk) begin
    int idx;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("busy[%0d]", m), busy_w[m], (st[m] != 0) ? 1 : 0);
      chk($sformatf("pending[%0d]", m), pend_w[m], pend[m]);
      chk($sformatf("roundCnt[%0d]", m), cnt_w[m], cnt[m]);
      chk($sformatf("fin[%0d]", m), fin_w[m], efin[m]);
      chk($sformatf("timeout[%0d]", m), to_w[m], eto[m]);
      if (fin_w[m] || to_w[m]) begin
        if (fin_w[m]) begin fin_seen[m]++; fin_cyc[m] = cyc; end
        if (to_w[m])  begin to_seen[m]++;  to_cyc[m]  = cyc; end
        idx = -1;
        foreach (evq[i]) if (idx < 0 && evq[i].m == m) idx = i;
        if (idx < 0) begin
          chk($sformatf("unexpected_pulse[%0d]", m), 1, 0);
        end else begin
          chk($sformatf("ev_kind[%0d]", m), fin_w[m], evq[idx].is_fin);
          chk($sformatf("ev_excl[%0d]", m), fin_w[m] & to_w[m], 0);
          chk($sformatf("ev_cyc[%0d]", m), cyc, evq[idx].cyc);
          chk($sformatf("ev_pend[%0d]", m), pend_w[m], evq[idx].pend);
          chk($sformatf("ev_cnt[%0d]", m), cnt_w[m], evq[idx].cnt);
          evq.delete(idx);
        end
      end
    end
  end

  // d<0 means that req never rises this round
  task automatic round(input int d0, input int d1, input int len,
                       input int l, input bit rnd_arm, output int ca);
    @(negedge clk); #1;
    lim = 16'(l);
    ca  = cyc;
    for (int t = 0; t < len; t++) begin
      if (t > 0) begin @(negedge clk); #1; end
      arm     = (t == 0) || (rnd_arm && $urandom_range(0, 7) == 0);
      reqs[0] = (d0 >= 0) && (t >= d0);
      reqs[1] = (d1 >= 0) && (t >= d1);
    end
    @(negedge clk); #1;
    arm  = 1'b0;
    reqs = 2'b00;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int ca, f0, f1, t0, r;
    rst_n = 1'b0; reqs = 2'b00; arm = 1'b0; lim = '0;
    repeat (3) @(negedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("rst_fin", fin_w[m], 0);
      chk("rst_timeout", to_w[m], 0);
      chk("rst_pending", pend_w[m], 0);
      chk("rst_busy", busy_w[m], 0);
      chk("rst_cnt", cnt_w[m], 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    f0 = fin_seen[1];
    round(3, 10, 20, 0, 1'b0, ca);
    chk("all_fin_once", fin_seen[1] - f0, 1);
    chk("all_fin_cyc", fin_cyc[1], ca + 10 + SS + 1);
    chk("all_cnt", cnt_w[1], 1);
    chk("all_busy_after", busy_w[1], 0);

    f0 = fin_seen[0];
    round(6, 2, 20, 0, 1'b0, ca);
    chk("any_fin_once", fin_seen[0] - f0, 1);
    chk("any_fin_cyc", fin_cyc[0], ca + 2 + SS + 1);
    chk("any_pending_kept", pend_w[0], 2'b01);

    f1 = fin_seen[1]; t0 = to_seen[1]; r = cnt_w[1];
    round(2, -1, 20, 5, 1'b0, ca);
    chk("to_pulse", to_seen[1] - t0, 1);
    chk("to_cyc", to_cyc[1], ca + 6);
    chk("to_no_fin", fin_seen[1] - f1, 0);
    chk("to_pending", pend_w[1], 2'b10);
    chk("to_cnt", cnt_w[1], r);

    f1 = fin_seen[1]; t0 = to_seen[1];
    round(1, 4, 20, 6, 1'b0, ca);
    chk("tie_fin", fin_seen[1] - f1, 1);
    chk("tie_no_to", to_seen[1] - t0, 0);
    chk("tie_cyc", fin_cyc[1], ca + 7);

    r = cnt_w[1];
    for (int k = 0; k < 256; k++) begin
      round($urandom_range(0, 5), $urandom_range(0, 5), 12, 0, 1'b0, ca);
    end
    chk("wrap_cnt", cnt_w[1], r);

    for (int k = 0; k < 60; k++) begin
      int l, a, b;
      l = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(3, 12);
      a = $urandom_range(0, 10);
      b = $urandom_range(0, 10);
      if (l != 0 && $urandom_range(0, 3) == 0) a = -1;
      round(a, b, 16, l, 1'b1, ca);
    end
    @(negedge clk); #1;
    lim = 16'd4;
    repeat (20) @(negedge clk);

    f0 = fin_seen[1] + fin_seen[0];
    t0 = to_seen[1] + to_seen[0];
    #1;
    arm = 1'b1;
    reqs = 2'b01;
    @(negedge clk); #1;
    arm = 1'b0;
    @(negedge clk); #1;
    chk("mid_busy", busy_w[1], 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy_w[1], 0);
    chk("mid_rst_pend", pend_w[1], 0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    reqs = 2'b00;
    repeat (4) @(negedge clk);
    chk("mid_no_fin", fin_seen[1] + fin_seen[0] - f0, 0);
    chk("mid_no_to", to_seen[1] + to_seen[0] - t0, 0);
    f1 = fin_seen[1];
    round(2, 4, 20, 0, 1'b0, ca);
    chk("post_rst_fin", fin_seen[1] - f1, 1);
    chk("post_rst_cnt", cnt_w[1], 1);

    chk("leftover_events", evq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
